spi_mode_ctrl: RTL and testbench
================================

// Module: spi_mode_ctrl
// PURPOSE
//  Parametrised SPI master/slave mode controller between the register block and the master/slave SPI cores.
//  Routes send/receive data and end strobes to the selected core. Drives pad output enables for NUM_SS slave selects.
//  Mode changes are safe: an in-flight frame drains first, then a guard gap with every pad OE low.
// PARAMETERS
//  DATA_W     8   send/receive data width
//  NUM_SS     1   number of slave-select pads (ss_oe_o width)
//  GUARD_CYC  4   cycles with every OE low between modes (must be >=1)
//  DRAIN_MAX  255 drain timeout in cycles; used only with SPI_MODE_CTRL_DRAIN_TIMEOUT_EN
// PORTS
//  clk_i               in  1       system clock
//  rst_i               in  1       reset; synchronous, active-high
//  spi_en_i            in  1       SPI enable
//  master_req_i        in  1       requested mode: 1=master, 0=slave
//  send_data_i         in  DATA_W  data to transmit
//  master_busy_i       in  1       master core mid-frame
//  slave_busy_i        in  1       slave core mid-frame
//  master_load_end_i / slave_load_end_i         in 1  load-end strobes
//  master_convey_end_i / slave_convey_end_i     in 1  convey-end strobes
//  master_frame_end_i / slave_frame_end_i       in 1  frame-end strobes
//  master_rcv_data_i / slave_rcv_data_i         in DATA_W  received data
//  master_o            out 1       effective mode (mode_q)
//  switching_o         out 1       1 in DRAIN or GUARD
//  en_master_o         out 1       master core enable
//  en_slave_o          out 1       slave core enable
//  master_send_data_o  out DATA_W  send_data_i if mode_q=1, else 0
//  slave_send_data_o   out DATA_W  send_data_i if mode_q=0, else 0
//  load_end_o / convey_end_o / frame_end_o      out 1  muxed strobes
//  rcv_data_o          out DATA_W  received data from the mode_q core
//  ss_oe_o             out NUM_SS  slave-select pad OEs
//  sck_oe_o / mosi_oe_o / miso_oe_o             out 1  pad OEs
//  timeout_o           out 1       drain-timeout pulse (0 if feature absent)
// BEHAVIOUR
//  - FSM states: OFF, GUARD, ACTIVE, DRAIN. Reset: state OFF, mode_q=0, guard counter=0. Every output is 0 in reset.
//  - OFF: enables and OEs are 0. On spi_en_i=1, load mode_q<=master_req_i, then go to GUARD.
//  - GUARD: runs for exactly GUARD_CYC cycles, then goes to ACTIVE. Enables and OEs are 0.
//  - ACTIVE: en_master_o=mode_q; en_slave_o=~mode_q.
//    - If master_req_i!=mode_q, go to DRAIN.
//  - DRAIN: enables held. Exits when busy of the mode_q core is 0; same-cycle mode_q<=~mode_q, then GUARD.
//    - If master_req_i returns to mode_q before busy drops, go back to ACTIVE with no gap.
//  - spi_en_i=0 in any state: go to OFF next cycle. This aborts DRAIN and GUARD; mode_q is kept.
//  - OEs are registered, 1-cycle latency from state/mode_q:
//    - ss_oe_o[all], sck_oe_o, mosi_oe_o = mode_q & (ACTIVE|DRAIN).
//    - miso_oe_o = ~mode_q & (ACTIVE|DRAIN).
//    - Never both directions in the same cycle.
//  - Strobe/data muxes are combinational on mode_q. Strobes are gated to 0 outside ACTIVE|DRAIN; rcv_data_o is not gated.
//  - Enables are combinational from state, so the core is enabled one cycle before its OEs rise.
// CONFIGURATION
//  - SPI_MODE_CTRL_DRAIN_TIMEOUT_EN defined:
//    - A counter runs in DRAIN. On reaching DRAIN_MAX cycles, the switch is forced as if busy had dropped.
//    - timeout_o pulses for 1 cycle; the counter clears on leaving DRAIN.
//  - Undefined: DRAIN waits indefinitely, and timeout_o is tied to 0.
// STRUCTURE
//  - spi_pkg holds:
//    - the state typedef (OFF/GUARD/ACTIVE/DRAIN);
//    - the MODE_MASTER/MODE_SLAVE constants;
//    - a clog2-based counter-width function.
//  - Sub-module spi_cyc_cnt: a load/decrement-to-zero counter with a done flag, used for GUARD and the DRAIN timeout.
// TESTING
//  1. spi_en_i 0->1, master_req_i=1, GUARD_CYC=4:
//     en_master_o rises after 4 guard cycles; sck/mosi/ss_oe rise 1 cycle later; miso_oe_o stays 0.
//  2. ACTIVE master, busy=1, master_req_i->0:
//     OEs hold while busy. busy->0 gives all OEs 0 for 4 cycles, then miso_oe_o=1 and en_slave_o=1.
//  3. In DRAIN, master_req_i pulses back to 1 before busy drops:
//     returns to ACTIVE; OEs never drop; switching_o high only in the DRAIN cycles.
//  4. spi_en_i=0 mid-GUARD and mid-DRAIN: OFF next cycle with all OEs and enables 0. Re-enable restarts GUARD.
//  5. Timeout defined, DRAIN_MAX=8, busy stuck at 1:
//     timeout_o pulses at DRAIN cycle 8, then GUARD. Undefined: stays in DRAIN, timeout_o=0.
//  6. Strobe/data routing: slave_frame_end_i=1 in master ACTIVE gives frame_end_o=0.
//     send_data_i=8'hA5 gives master_send_data_o=A5 and slave_send_data_o=00. Same checks with DATA_W=16.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI master/slave mode controller.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_GUARD  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DRAIN  = 2'd3
  } spi_state_e;

  localparam logic MODE_MASTER = 1'b1;
  localparam logic MODE_SLAVE  = 1'b0;

  // Width of a down-counter that is loaded with (max_val - 1).
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/spi_cyc_cnt.sv
// Load / decrement-to-zero cycle counter; done_c is high while the count is zero.
module spi_cyc_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         clr,
  input  logic         dec,
  output logic         done_c
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign done_c = (cnt_q == '0);

endmodule

// File: rtl/spi_mode_ctrl.sv
// SPI master/slave mode controller: routes core traffic, drives pad OEs, sequences safe mode changes.
// Optional drain timeout enabled by defining SPI_MODE_CTRL_DRAIN_TIMEOUT_EN.
module spi_mode_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned NUM_SS    = 1,
  parameter int unsigned GUARD_CYC = 4,
  parameter int unsigned DRAIN_MAX = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              spi_en_i,
  input  logic              master_req_i,
  input  logic [DATA_W-1:0] send_data_i,
  input  logic              master_busy_i,
  input  logic              slave_busy_i,
  input  logic              master_load_end_i,
  input  logic              slave_load_end_i,
  input  logic              master_convey_end_i,
  input  logic              slave_convey_end_i,
  input  logic              master_frame_end_i,
  input  logic              slave_frame_end_i,
  input  logic [DATA_W-1:0] master_rcv_data_i,
  input  logic [DATA_W-1:0] slave_rcv_data_i,
  output logic              master_o,
  output logic              switching_o,
  output logic              en_master_o,
  output logic              en_slave_o,
  output logic [DATA_W-1:0] master_send_data_o,
  output logic [DATA_W-1:0] slave_send_data_o,
  output logic              load_end_o,
  output logic              convey_end_o,
  output logic              frame_end_o,
  output logic [DATA_W-1:0] rcv_data_o,
  output logic [NUM_SS-1:0] ss_oe_o,
  output logic              sck_oe_o,
  output logic              mosi_oe_o,
  output logic              miso_oe_o,
  output logic              timeout_o
);

  localparam int unsigned GUARD_W = cnt_w(GUARD_CYC);

  if ((GUARD_CYC < 1) || (DRAIN_MAX < 1)) begin : g_bad_param
    $error("spi_mode_ctrl: GUARD_CYC and DRAIN_MAX must be >= 1");
  end

  spi_state_e state_q;
  logic       mode_q;
  logic       oe_m_q;
  logic       oe_s_q;

  logic live_c;
  logic mismatch_c;
  logic cur_busy_c;
  logic drain_to_c;
  logic drain_exit_c;
  logic guard_load_c;
  logic guard_dec_c;
  logic guard_clr_c;
  logic guard_done_c;

  // Transition qualifiers shared by the FSM and both counters.
  always_comb begin
    live_c       = 1'b0;
    mismatch_c   = 1'b0;
    cur_busy_c   = 1'b0;
    drain_exit_c = 1'b0;
    guard_load_c = 1'b0;
    guard_dec_c  = 1'b0;
    guard_clr_c  = 1'b0;

    live_c       = (state_q == ST_ACTIVE) || (state_q == ST_DRAIN);
    mismatch_c   = (master_req_i != mode_q);
    cur_busy_c   = (mode_q == MODE_MASTER) ? master_busy_i : slave_busy_i;
    drain_exit_c = spi_en_i && (state_q == ST_DRAIN) && mismatch_c &&
                   (!cur_busy_c || drain_to_c);
    guard_load_c = spi_en_i && ((state_q == ST_OFF) || drain_exit_c);
    guard_dec_c  = spi_en_i && (state_q == ST_GUARD) && !guard_done_c;
    guard_clr_c  = (state_q != ST_GUARD);
  end

  spi_cyc_cnt #(
    .W (GUARD_W)
  ) u_guard_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load     (guard_load_c),
    .load_val (GUARD_W'(GUARD_CYC - 1)),
    .clr      (guard_clr_c),
    .dec      (guard_dec_c),
    .done_c   (guard_done_c)
  );

`ifdef SPI_MODE_CTRL_DRAIN_TIMEOUT_EN
  localparam int unsigned DRAIN_W = cnt_w(DRAIN_MAX);

  logic drain_done_c;

  // Loaded on entry to DRAIN, so done_c rises on the DRAIN_MAX-th drain cycle.
  spi_cyc_cnt #(
    .W (DRAIN_W)
  ) u_drain_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load     (spi_en_i && (state_q == ST_ACTIVE) && mismatch_c),
    .load_val (DRAIN_W'(DRAIN_MAX - 1)),
    .clr      (state_q != ST_DRAIN),
    .dec      ((state_q == ST_DRAIN) && !drain_done_c),
    .done_c   (drain_done_c)
  );

  assign drain_to_c = spi_en_i && (state_q == ST_DRAIN) && mismatch_c &&
                      cur_busy_c && drain_done_c;
  assign timeout_o  = drain_to_c;
`else
  assign drain_to_c = 1'b0;
  assign timeout_o  = 1'b0;
`endif

  // Mode FSM with registered pad OEs; disabling drops OEs on the same edge as OFF.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_OFF;
      mode_q  <= MODE_SLAVE;
      oe_m_q  <= 1'b0;
      oe_s_q  <= 1'b0;
    end else begin
      oe_m_q <= spi_en_i && live_c && (mode_q == MODE_MASTER);
      oe_s_q <= spi_en_i && live_c && (mode_q == MODE_SLAVE);
      if (!spi_en_i) begin
        state_q <= ST_OFF;
      end else begin
        case (state_q)
          ST_OFF: begin
            mode_q  <= master_req_i;
            state_q <= ST_GUARD;
          end
          ST_GUARD: begin
            if (guard_done_c) state_q <= ST_ACTIVE;
          end
          ST_ACTIVE: begin
            if (mismatch_c) state_q <= ST_DRAIN;
          end
          ST_DRAIN: begin
            if (!mismatch_c) begin
              state_q <= ST_ACTIVE;
            end else if (drain_exit_c) begin
              mode_q  <= ~mode_q;
              state_q <= ST_GUARD;
            end
          end
          default: state_q <= ST_OFF;
        endcase
      end
    end
  end

  assign master_o           = mode_q;
  assign switching_o        = (state_q == ST_GUARD) || (state_q == ST_DRAIN);
  assign en_master_o        = live_c && (mode_q == MODE_MASTER);
  assign en_slave_o         = live_c && (mode_q == MODE_SLAVE);
  assign master_send_data_o = (mode_q == MODE_MASTER) ? send_data_i : '0;
  assign slave_send_data_o  = (mode_q == MODE_SLAVE) ? send_data_i : '0;
  assign load_end_o         = live_c && ((mode_q == MODE_MASTER) ? master_load_end_i : slave_load_end_i);
  assign convey_end_o       = live_c && ((mode_q == MODE_MASTER) ? master_convey_end_i : slave_convey_end_i);
  assign frame_end_o        = live_c && ((mode_q == MODE_MASTER) ? master_frame_end_i : slave_frame_end_i);
  assign rcv_data_o         = (mode_q == MODE_MASTER) ? master_rcv_data_i : slave_rcv_data_i;
  assign ss_oe_o            = {NUM_SS{oe_m_q}};
  assign sck_oe_o           = oe_m_q;
  assign mosi_oe_o          = oe_m_q;
  assign miso_oe_o          = oe_s_q;

endmodule

// File: tb/tb_spi_mode_ctrl.sv
// Directed scoreboard bench for spi_mode_ctrl (8-bit/1-SS and 16-bit/2-SS instances).
module tb_spi_mode_ctrl;

  localparam int unsigned GC = 4;
  localparam int unsigned DM = 8;
`ifdef SPI_MODE_CTRL_DRAIN_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk, rst, spi_en, master_req, master_busy, slave_busy;
  logic m_load_end, s_load_end, m_convey_end, s_convey_end, m_frame_end, s_frame_end;
  logic [7:0]  send_data, m_rcv, s_rcv;
  logic [15:0] send16, m_rcv16, s_rcv16;

  logic       master_o, switching_o, en_master_o, en_slave_o;
  logic [7:0] master_send_data_o, slave_send_data_o, rcv_data_o;
  logic       load_end_o, convey_end_o, frame_end_o;
  logic [0:0] ss_oe_o;
  logic       sck_oe_o, mosi_oe_o, miso_oe_o, timeout_o;

  logic        master16, switching16, en_master16, en_slave16;
  logic [15:0] msend16, ssend16, rcv16;
  logic        load_end16, convey_end16, frame_end16;
  logic [1:0]  ss16;
  logic        sck16, mosi16, miso16, timeout16;

  int n_assert = 0;
  int n_fail   = 0;
  string       sb_tag[$];
  logic [31:0] sb_exp[$];

  spi_mode_ctrl #(.DATA_W(8), .NUM_SS(1), .GUARD_CYC(GC), .DRAIN_MAX(DM)) u_dut (
    .clk_i(clk), .rst_i(rst), .spi_en_i(spi_en), .master_req_i(master_req),
    .send_data_i(send_data), .master_busy_i(master_busy), .slave_busy_i(slave_busy),
    .master_load_end_i(m_load_end), .slave_load_end_i(s_load_end),
    .master_convey_end_i(m_convey_end), .slave_convey_end_i(s_convey_end),
    .master_frame_end_i(m_frame_end), .slave_frame_end_i(s_frame_end),
    .master_rcv_data_i(m_rcv), .slave_rcv_data_i(s_rcv),
    .master_o(master_o), .switching_o(switching_o), .en_master_o(en_master_o),
    .en_slave_o(en_slave_o), .master_send_data_o(master_send_data_o),
    .slave_send_data_o(slave_send_data_o), .load_end_o(load_end_o),
    .convey_end_o(convey_end_o), .frame_end_o(frame_end_o), .rcv_data_o(rcv_data_o),
    .ss_oe_o(ss_oe_o), .sck_oe_o(sck_oe_o), .mosi_oe_o(mosi_oe_o),
    .miso_oe_o(miso_oe_o), .timeout_o(timeout_o)
  );

  spi_mode_ctrl #(.DATA_W(16), .NUM_SS(2), .GUARD_CYC(GC), .DRAIN_MAX(DM)) u_dut16 (
    .clk_i(clk), .rst_i(rst), .spi_en_i(spi_en), .master_req_i(master_req),
    .send_data_i(send16), .master_busy_i(master_busy), .slave_busy_i(slave_busy),
    .master_load_end_i(m_load_end), .slave_load_end_i(s_load_end),
    .master_convey_end_i(m_convey_end), .slave_convey_end_i(s_convey_end),
    .master_frame_end_i(m_frame_end), .slave_frame_end_i(s_frame_end),
    .master_rcv_data_i(m_rcv16), .slave_rcv_data_i(s_rcv16),
    .master_o(master16), .switching_o(switching16), .en_master_o(en_master16),
    .en_slave_o(en_slave16), .master_send_data_o(msend16),
    .slave_send_data_o(ssend16), .load_end_o(load_end16),
    .convey_end_o(convey_end16), .frame_end_o(frame_end16), .rcv_data_o(rcv16),
    .ss_oe_o(ss16), .sck_oe_o(sck16), .mosi_oe_o(mosi16),
    .miso_oe_o(miso16), .timeout_o(timeout16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  // Control snapshot: {master, switching, en_m, en_s, sck, mosi, miso, ss, timeout}
  function automatic logic [31:0] v(input logic m, sw, em, es, mo, mi, to);
    return {23'd0, m, sw, em, es, mo, mo, mi, mo, to};
  endfunction

  function automatic logic [31:0] obs();
    return {23'd0, master_o, switching_o, en_master_o, en_slave_o,
            sck_oe_o, mosi_oe_o, miso_oe_o, ss_oe_o[0], timeout_o};
  endfunction

  function automatic logic [31:0] obs16();
    return {23'd0, master16, switching16, en_master16, en_slave16,
            sck16, mosi16, miso16, ss16[0], timeout16};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] e);
    sb_tag.push_back(tag);
    sb_exp.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] o);
    string       t;
    logic [31:0] e;
    n_assert++;
    if (sb_exp.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0h expected <none>", o);
    end else begin
      t = sb_tag.pop_front();
      e = sb_exp.pop_front();
      assert (o === e) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", t, o, e);
      end
    end
  endtask

  task automatic bring_up(input logic req, input string tag);
    spi_en     = 1'b1;
    master_req = req;
    for (int i = 0; i < GC; i++) begin
      push({tag, "_guard"}, v(req, 1, 0, 0, 0, 0, 0));
      tick(1);
      pop_chk(obs());
    end
    push({tag, "_en"}, v(req, 0, req, !req, 0, 0, 0));
    tick(1);
    pop_chk(obs());
    push({tag, "_oe"}, v(req, 0, req, !req, req, !req, 0));
    tick(1);
    pop_chk(obs());
  endtask

  initial begin
    int n_drain;
    rst = 1'b1; spi_en = 1'b0; master_req = 1'b0; master_busy = 1'b0; slave_busy = 1'b0;
    m_load_end = 1'b0; s_load_end = 1'b0; m_convey_end = 1'b0; s_convey_end = 1'b0;
    m_frame_end = 1'b0; s_frame_end = 1'b0;
    send_data = '0; m_rcv = '0; s_rcv = '0; send16 = '0; m_rcv16 = '0; s_rcv16 = '0;

    push("reset_ctrl", 32'd0);
    push("reset_data", 32'd0);
    tick(3);
    pop_chk(obs());
    pop_chk({master_send_data_o, slave_send_data_o, rcv_data_o, 5'd0,
             load_end_o, convey_end_o, frame_end_o});

    rst = 1'b0;
    push("off_idle", 32'd0);
    tick(1);
    pop_chk(obs());

    // Enable as master: GC guard cycles, enable, then OEs one cycle later
    bring_up(1'b1, "t1");

    // Routing while master ACTIVE
    s_frame_end = 1'b1; s_convey_end = 1'b1; m_load_end = 1'b1;
    send_data = 8'hA5; send16 = 16'hA5A5;
    m_rcv = 8'h3C; s_rcv = 8'hC3; m_rcv16 = 16'h1234; s_rcv16 = 16'h4321;
    push("t6_frame_end_gated", 32'd0);
    push("t6_convey_end_gated", 32'd0);
    push("t6_load_end", 32'd1);
    push("t6_msend", 32'hA5);
    push("t6_ssend", 32'h00);
    push("t6_rcv", 32'h3C);
    push("t6_ctrl16", v(1, 0, 1, 0, 1, 0, 0));
    push("t6_ss16", 32'd3);
    push("t6_msend16", 32'hA5A5);
    push("t6_ssend16", 32'h0);
    push("t6_rcv16", 32'h1234);
    push("t6_strobes16", 32'b010);
    #1;
    pop_chk(frame_end_o);
    pop_chk(convey_end_o);
    pop_chk(load_end_o);
    pop_chk(master_send_data_o);
    pop_chk(slave_send_data_o);
    pop_chk(rcv_data_o);
    pop_chk(obs16());
    pop_chk(ss16);
    pop_chk(msend16);
    pop_chk(ssend16);
    pop_chk(rcv16);
    pop_chk({load_end16, frame_end16, convey_end16} == 3'b100 ? 32'b010 : 32'b111);
    s_frame_end = 1'b0; s_convey_end = 1'b0; m_load_end = 1'b0;

    // Master -> slave with busy holding the drain
    master_busy = 1'b1; master_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      push("t2_drain", v(1, 1, 1, 0, 1, 0, 0));
      tick(1);
      pop_chk(obs());
    end
    master_busy = 1'b0;
    push("t2_g1", v(0, 1, 0, 0, 1, 0, 0));
    tick(1);
    pop_chk(obs());
    s_frame_end = 1'b1;
    push("t2_g2", v(0, 1, 0, 0, 0, 0, 0));
    push("t2_strobe_guard", 32'd0);
    tick(1);
    pop_chk(obs());
    pop_chk(frame_end_o);
    for (int k = 0; k < 2; k++) begin
      push("t2_g34", v(0, 1, 0, 0, 0, 0, 0));
      tick(1);
      pop_chk(obs());
    end
    push("t2_a1", v(0, 0, 0, 1, 0, 0, 0));
    push("t2_strobe_slave", 32'd1);
    tick(1);
    pop_chk(obs());
    pop_chk(frame_end_o);
    push("t2_a2", v(0, 0, 0, 1, 0, 1, 0));
    push("t2_rcv_slave", 32'hC3);
    push("t2_ssend", 32'hA5);
    tick(1);
    pop_chk(obs());
    pop_chk(rcv_data_o);
    pop_chk(slave_send_data_o);
    s_frame_end = 1'b0;

    // Request bounces back before busy drops
    slave_busy = 1'b1; master_req = 1'b1;
    push("t3_drain", v(0, 1, 0, 1, 0, 1, 0));
    tick(1);
    pop_chk(obs());
    master_req = 1'b0;
    push("t3_back", v(0, 0, 0, 1, 0, 1, 0));
    push("t3_hold", v(0, 0, 0, 1, 0, 1, 0));
    tick(1);
    pop_chk(obs());
    tick(1);
    pop_chk(obs());

    // Disable mid-DRAIN and mid-GUARD
    master_req = 1'b1;
    push("t4_drain", v(0, 1, 0, 1, 0, 1, 0));
    tick(1);
    pop_chk(obs());
    spi_en = 1'b0;
    push("t4_off_from_drain", v(0, 0, 0, 0, 0, 0, 0));
    tick(1);
    pop_chk(obs());
    slave_busy = 1'b0; spi_en = 1'b1;
    push("t4_guard_a", v(1, 1, 0, 0, 0, 0, 0));
    push("t4_guard_b", v(1, 1, 0, 0, 0, 0, 0));
    tick(1);
    pop_chk(obs());
    tick(1);
    pop_chk(obs());
    spi_en = 1'b0;
    push("t4_off_from_guard", v(1, 0, 0, 0, 0, 0, 0));
    tick(1);
    pop_chk(obs());
    bring_up(1'b1, "t4_restart");

    // Busy stuck high: forced switch with timeout, or indefinite drain without it
    master_busy = 1'b1; master_req = 1'b0;
    n_drain = TO_EN ? DM : 12;
    for (int k = 1; k <= n_drain; k++) begin
      push("t5_drain", v(1, 1, 1, 0, 1, 0, TO_EN && (k == DM)));
      tick(1);
      pop_chk(obs());
    end
    if (!TO_EN) master_busy = 1'b0;
    push("t5_guard1", v(0, 1, 0, 0, 1, 0, 0));
    tick(1);
    pop_chk(obs());
    master_busy = 1'b0;
    push("t5_guard2", v(0, 1, 0, 0, 0, 0, 0));
    tick(1);
    pop_chk(obs());

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
